sudoku_checker: RTL and testbench

Post-solve verifier for the Sudoku flow. After the solver has written its 81-cell answer into the solution RAM, this block reads the grid back through the same RAM port and reads the original puzzle from the puzzle ROM. It checks every row, column and 3x3 box, and confirms every given is preserved. It reports pass/fail with the first offending cell, so a bench or on-chip self-test can grade the solver without a golden file.

---
 rtl/sudoku_pkg.sv | 17 +
 rtl/sudoku_unit_tracker.sv | 26 ++
 rtl/sudoku_checker.sv | 138 +++++++++++++
 tb/tb_sudoku_checker.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sudoku_pkg.sv
// rtl/sudoku_pkg.sv - shared sizes, enums and box lookup for the sudoku checker
package sudoku_pkg;
  localparam int N_CELLS = 81;
  localparam int ADDR_W  = 7;
  localparam int DATA_W  = 8;

  typedef enum logic [1:0] {ERR_NONE, ERR_RANGE, ERR_GIVEN, ERR_DUP} err_e;
  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_e;

  function automatic logic [3:0] box_of(input logic [3:0] r, input logic [3:0] c);
    logic [3:0] br;
    logic [3:0] bc;
    br = (r < 4'd3) ? 4'd0 : (r < 4'd6) ? 4'd3 : 4'd6;
    bc = (c < 4'd3) ? 4'd0 : (c < 4'd6) ? 4'd1 : 4'd2;
    return br + bc;
  endfunction
endpackage

// File: rtl/sudoku_unit_tracker.sv
// rtl/sudoku_unit_tracker.sv - nine 9-bit digit masks with clear and test-and-set
module sudoku_unit_tracker
  import sudoku_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clear_i,
  input  logic       set_i,
  input  logic [3:0] unit_i,
  input  logic [8:0] digit_i,
  output logic       hit_o
);
  logic [8:0] mask_q [0:8];

  assign hit_o = |(mask_q[unit_i] & digit_i);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 9; i++) mask_q[i] <= '0;
    end else if (clear_i) begin
      for (int i = 0; i < 9; i++) mask_q[i] <= '0;
    end else if (set_i) begin
      mask_q[unit_i] <= mask_q[unit_i] | digit_i;
    end
  end
endmodule

// File: rtl/sudoku_checker.sv
// rtl/sudoku_checker.sv - reads solver grid and puzzle, checks rows/cols/boxes and givens
module sudoku_checker
  import sudoku_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              ROM_rd,
  output logic [ADDR_W-1:0] ROM_A,
  input  logic [DATA_W-1:0] ROM_Q,
  output logic              RAM_ceb,
  output logic              RAM_web,
  output logic [ADDR_W-1:0] RAM_A,
  output logic [DATA_W-1:0] RAM_D,
  input  logic [DATA_W-1:0] RAM_Q,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [1:0]        err_type,
  output logic [ADDR_W-1:0] err_addr
);
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              chk_v_q, chk_v_d;
  logic [ADDR_W-1:0] chk_k_q, chk_k_d;
  logic [3:0]        chk_r_q, chk_r_d, chk_c_q, chk_c_d;
  logic              pass_q, pass_d;
  err_e              err_q, err_d;
  logic [ADDR_W-1:0] err_addr_q, err_addr_d;

  logic       in_range, hit_r, hit_c, hit_b, mask_clear, mask_set;
  logic [8:0] v_onehot;
  err_e       cell_err;

  // Check stage works on the data returned for the cell issued one cycle earlier.
  always_comb begin
    in_range = (RAM_Q != '0) && (RAM_Q <= DATA_W'(9));
    v_onehot = in_range ? (9'd1 << (RAM_Q[3:0] - 4'd1)) : 9'd0;
    cell_err = ERR_NONE;
    if (chk_v_q) begin
      if (!in_range)                         cell_err = ERR_RANGE;
      else if (ROM_Q != '0 && ROM_Q != RAM_Q) cell_err = ERR_GIVEN;
      else if (hit_r || hit_c || hit_b)       cell_err = ERR_DUP;
    end
    mask_set   = chk_v_q && (cell_err == ERR_NONE);
    mask_clear = (state_q == S_IDLE) && start;
  end

  sudoku_unit_tracker u_row (.clk(clk), .rst(rst), .clear_i(mask_clear), .set_i(mask_set),
                             .unit_i(chk_r_q), .digit_i(v_onehot), .hit_o(hit_r));
  sudoku_unit_tracker u_col (.clk(clk), .rst(rst), .clear_i(mask_clear), .set_i(mask_set),
                             .unit_i(chk_c_q), .digit_i(v_onehot), .hit_o(hit_c));
  sudoku_unit_tracker u_box (.clk(clk), .rst(rst), .clear_i(mask_clear), .set_i(mask_set),
                             .unit_i(box_of(chk_r_q, chk_c_q)), .digit_i(v_onehot), .hit_o(hit_b));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      chk_v_q    <= 1'b0;
      chk_k_q    <= '0;
      chk_r_q    <= '0;
      chk_c_q    <= '0;
      pass_q     <= 1'b0;
      err_q      <= ERR_NONE;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      chk_v_q    <= chk_v_d;
      chk_k_q    <= chk_k_d;
      chk_r_q    <= chk_r_d;
      chk_c_q    <= chk_c_d;
      pass_q     <= pass_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    chk_v_d    = (state_q == S_READ);
    chk_k_d    = chk_k_q;
    chk_r_d    = chk_r_q;
    chk_c_d    = chk_c_q;
    pass_d     = pass_q;
    err_d      = err_q;
    err_addr_d = err_addr_q;
    case (state_q)
      S_IDLE: if (start) begin
        state_d    = S_READ;
        addr_d     = '0;
        chk_k_d    = '0;
        chk_r_d    = '0;
        chk_c_d    = '0;
        pass_d     = 1'b0;
        err_d      = ERR_NONE;
        err_addr_d = '0;
      end
      S_READ: begin
        addr_d = addr_q + 1'b1;
        if (addr_q == ADDR_W'(N_CELLS - 1)) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        state_d = S_DONE;
        pass_d  = (cell_err == ERR_NONE);
      end
      default: state_d = S_IDLE;
    endcase
    if (chk_v_q) begin
      chk_k_d = chk_k_q + 1'b1;
      chk_c_d = (chk_c_q == 4'd8) ? 4'd0 : chk_c_q + 4'd1;
      chk_r_d = (chk_c_q == 4'd8) ? chk_r_q + 4'd1 : chk_r_q;
      // First failure aborts; the read already in flight is simply never checked.
      if (cell_err != ERR_NONE) begin
        err_d      = cell_err;
        err_addr_d = chk_k_q;
        state_d    = S_DONE;
        chk_v_d    = 1'b0;
      end
    end
  end

  always_comb begin
    ROM_rd   = (state_q == S_READ);
    RAM_ceb  = !ROM_rd;
    ROM_A    = ROM_rd ? addr_q : '0;
    RAM_A    = ROM_rd ? addr_q : '0;
    RAM_web  = 1'b1;
    RAM_D    = '0;
    busy     = (state_q != S_IDLE);
    done     = (state_q == S_DONE);
    pass     = pass_q;
    err_type = err_q;
    err_addr = err_addr_q;
  end
endmodule

// File: tb/tb_sudoku_checker.sv
// tb/tb_sudoku_checker.sv - randomized self-checking bench for sudoku_checker
module tb_sudoku_checker;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       ROM_rd, RAM_ceb, RAM_web, busy, done, pass;
  logic [6:0] ROM_A, RAM_A, err_addr;
  logic [7:0] ROM_Q = '0, RAM_Q = '0, RAM_D;
  logic [1:0] err_type;

  int total = 0;
  int bad = 0;
  int web_bad = 0;
  int rom [81];
  int ram [81];

  always #5 clk = ~clk;

  sudoku_checker dut (
    .clk(clk), .rst(rst), .start(start),
    .ROM_rd(ROM_rd), .ROM_A(ROM_A), .ROM_Q(ROM_Q),
    .RAM_ceb(RAM_ceb), .RAM_web(RAM_web), .RAM_A(RAM_A), .RAM_D(RAM_D), .RAM_Q(RAM_Q),
    .busy(busy), .done(done), .pass(pass), .err_type(err_type), .err_addr(err_addr)
  );

  always @(posedge clk) begin
    if (ROM_rd)   ROM_Q <= 8'(rom[ROM_A]);
    if (!RAM_ceb) RAM_Q <= 8'(ram[RAM_A]);
  end

  always @(negedge clk) if (RAM_web !== 1'b1 || RAM_D !== 8'd0) web_bad++;

  // Random valid solution from a shifted base pattern, digit relabel and row shuffle within bands.
  task automatic make_grid(input int given_pct);
    int perm [9];
    int rmap [9];
    int j, t, rr;
    for (int i = 0; i < 9; i++) begin perm[i] = i + 1; rmap[i] = i; end
    for (int i = 8; i > 0; i--) begin
      j = $urandom_range(i, 0); t = perm[i]; perm[i] = perm[j]; perm[j] = t;
    end
    for (int b = 0; b < 3; b++)
      for (int i = 2; i > 0; i--) begin
        j = $urandom_range(i, 0); t = rmap[b*3+i]; rmap[b*3+i] = rmap[b*3+j]; rmap[b*3+j] = t;
      end
    for (int r = 0; r < 9; r++) begin
      rr = rmap[r];
      for (int c = 0; c < 9; c++) begin
        ram[r*9+c] = perm[(rr*3 + rr/3 + c) % 9];
        rom[r*9+c] = ($urandom_range(99, 0) < given_pct) ? ram[r*9+c] : 0;
      end
    end
  endtask

  // Reference: walk the cells in order and apply the rules directly against earlier cells.
  function automatic void ref_model(output int cyc, output logic p, output logic [1:0] et,
                                    output logic [6:0] ea);
    int v, g;
    cyc = 82; p = 1'b1; et = 2'd0; ea = 7'd0;
    for (int k = 0; k < 81; k++) begin
      v = ram[k]; g = rom[k];
      if (v < 1 || v > 9) et = 2'd1;
      else if (g != 0 && g != v) et = 2'd2;
      else
        for (int j = 0; j < k; j++)
          if (ram[j] == v && (j/9 == k/9 || j%9 == k%9 ||
              ((j/9)/3 == (k/9)/3 && (j%9)/3 == (k%9)/3))) et = 2'd3;
      if (et != 2'd0) begin
        cyc = k + 2; p = 1'b0; ea = 7'(k);
        return;
      end
    end
  endfunction

  task automatic run(input int start_at, output int cyc, output int ndone, output logic busy1,
                     output logic p, output logic [1:0] et, output logic [6:0] ea,
                     output logic busy_end);
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    cyc = -1; ndone = 0; busy1 = 1'b0; p = 1'b0; et = 2'd0; ea = 7'd0;
    for (int n = 1; n <= 100; n++) begin
      start = (n == start_at);
      @(posedge clk); #1;
      if (n == 1) busy1 = busy;
      if (done === 1'b1) begin
        ndone++;
        if (cyc < 0) begin cyc = n; p = pass; et = err_type; ea = err_addr; end
      end
    end
    start = 1'b0;
    busy_end = busy;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    total++; if ({ROM_rd, RAM_ceb, RAM_web, busy, done, pass} !== 6'b011000) begin
      bad++; $display("FAIL reset_ctrl got=%b want=011000", {ROM_rd, RAM_ceb, RAM_web, busy, done, pass});
    end
    total++; if ({ROM_A, RAM_A, RAM_D} !== 22'd0) begin
      bad++; $display("FAIL reset_bus got=%h want=0", {ROM_A, RAM_A, RAM_D});
    end
    total++; if (err_type !== 2'd0 || err_addr !== 7'd0) begin
      bad++; $display("FAIL reset_err got=%0d/%0d want=0/0", err_type, err_addr);
    end
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b0 || done !== 1'b0 || ROM_rd !== 1'b0) begin
      bad++; $display("FAIL reset_release got=%b%b%b want=000", busy, done, ROM_rd);
    end
  endtask

  task automatic test_clean;
    int cyc, nd; logic b1, p, be; logic [1:0] et; logic [6:0] ea;
    for (int t = 0; t < 3; t++) begin
      make_grid(40);
      web_bad = 0;
      run(0, cyc, nd, b1, p, et, ea, be);
      total++; if (cyc !== 82 || nd !== 1) begin
        bad++; $display("FAIL clean_timing got=%0d/%0d want=82/1", cyc, nd);
      end
      total++; if (p !== 1'b1 || et !== 2'd0 || ea !== 7'd0) begin
        bad++; $display("FAIL clean_result got=%b/%0d/%0d want=1/0/0", p, et, ea);
      end
      total++; if (b1 !== 1'b1 || be !== 1'b0) begin
        bad++; $display("FAIL clean_busy got=%b/%b want=1/0", b1, be);
      end
      total++; if (web_bad !== 0) begin
        bad++; $display("FAIL ram_web_held got=%0d want=0", web_bad);
      end
    end
  endtask

  task automatic test_dup_row;
    int cyc, nd; logic b1, p, be; logic [1:0] et; logic [6:0] ea;
    make_grid(30);
    ram[1] = ram[0]; rom[1] = 0;
    run(0, cyc, nd, b1, p, et, ea, be);
    total++; if (cyc !== 3 || p !== 1'b0 || et !== 2'd3 || ea !== 7'd1) begin
      bad++; $display("FAIL dup_row got=%0d/%b/%0d/%0d want=3/0/3/1", cyc, p, et, ea);
    end
  endtask

  task automatic test_range;
    int cyc, nd; logic b1, p, be; logic [1:0] et; logic [6:0] ea;
    make_grid(30);
    ram[80] = 0;
    run(0, cyc, nd, b1, p, et, ea, be);
    total++; if (cyc !== 82 || p !== 1'b0 || et !== 2'd1 || ea !== 7'd80) begin
      bad++; $display("FAIL range_80 got=%0d/%b/%0d/%0d want=82/0/1/80", cyc, p, et, ea);
    end
    make_grid(30);
    ram[12] = 8'h0A;
    run(0, cyc, nd, b1, p, et, ea, be);
    total++; if (cyc !== 14 || et !== 2'd1 || ea !== 7'd12) begin
      bad++; $display("FAIL range_12 got=%0d/%0d/%0d want=14/1/12", cyc, et, ea);
    end
  endtask

  task automatic test_given;
    int cyc, nd; logic b1, p, be; logic [1:0] et; logic [6:0] ea;
    make_grid(30);
    rom[5] = (ram[5] % 9) + 1;
    run(0, cyc, nd, b1, p, et, ea, be);
    total++; if (cyc !== 7 || p !== 1'b0 || et !== 2'd2 || ea !== 7'd5) begin
      bad++; $display("FAIL given got=%0d/%b/%0d/%0d want=7/0/2/5", cyc, p, et, ea);
    end
    make_grid(30);
    rom[5] = 3; ram[5] = 0;
    run(0, cyc, nd, b1, p, et, ea, be);
    total++; if (et !== 2'd1 || ea !== 7'd5) begin
      bad++; $display("FAIL range_before_given got=%0d/%0d want=1/5", et, ea);
    end
  endtask

  task automatic test_random_errors;
    int cyc, nd, ecyc; logic b1, p, be, ep; logic [1:0] et, eet; logic [6:0] ea, eea;
    for (int t = 0; t < 20; t++) begin
      make_grid(50);
      for (int m = $urandom_range(2, 0); m > 0; m--) ram[$urandom_range(80, 0)] = $urandom_range(15, 0);
      if ($urandom_range(1, 0) == 1) rom[$urandom_range(80, 0)] = $urandom_range(9, 0);
      ref_model(ecyc, ep, eet, eea);
      run(0, cyc, nd, b1, p, et, ea, be);
      total++; if (cyc !== ecyc || nd !== 1 || p !== ep || et !== eet || ea !== eea) begin
        bad++; $display("FAIL random_%0d got=%0d/%0d/%b/%0d/%0d want=%0d/1/%b/%0d/%0d",
                        t, cyc, nd, p, et, ea, ecyc, ep, eet, eea);
      end
    end
  endtask

  task automatic test_start_ignored;
    int cyc, nd; logic b1, p, be; logic [1:0] et; logic [6:0] ea;
    make_grid(40);
    run(10, cyc, nd, b1, p, et, ea, be);
    total++; if (cyc !== 82 || nd !== 1 || p !== 1'b1) begin
      bad++; $display("FAIL start_in_read got=%0d/%0d/%b want=82/1/1", cyc, nd, p);
    end
    run(83, cyc, nd, b1, p, et, ea, be);
    total++; if (nd !== 1 || be !== 1'b0) begin
      bad++; $display("FAIL start_in_done got=%0d/%b want=1/0", nd, be);
    end
  endtask

  task automatic test_reset_mid;
    int cyc, nd, nd_rst; logic b1, p, be; logic [1:0] et; logic [6:0] ea;
    make_grid(40);
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (39) @(posedge clk);
    @(posedge clk); rst = 1'b1;
    #1;
    total++; if ({ROM_rd, RAM_ceb, RAM_web, busy, done, pass, err_type} !== 8'b01100000 ||
                 {ROM_A, RAM_A, err_addr} !== 21'd0) begin
      bad++; $display("FAIL reset_mid got=%b%b%b%b%b%b_%0d addr=%0d/%0d/%0d want=011000_0 addr=0/0/0",
                      ROM_rd, RAM_ceb, RAM_web, busy, done, pass, err_type, ROM_A, RAM_A, err_addr);
    end
    nd_rst = 0;
    repeat (3) begin @(negedge clk); if (done !== 1'b0) nd_rst++; end
    rst = 1'b0;
    repeat (50) begin @(negedge clk); if (done !== 1'b0) nd_rst++; end
    total++; if (nd_rst !== 0) begin
      bad++; $display("FAIL reset_no_done got=%0d want=0", nd_rst);
    end
    run(0, cyc, nd, b1, p, et, ea, be);
    total++; if (cyc !== 82 || p !== 1'b1 || et !== 2'd0) begin
      bad++; $display("FAIL after_reset got=%0d/%b/%0d want=82/1/0", cyc, p, et);
    end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_dup_row();
    test_range();
    test_given();
    test_random_errors();
    test_start_ignored();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
